// File: rtl/ring_buffer_pkg.sv
// Shared sizing, packet type and drain FSM encoding for the ring-router buffer read side.
package ring_buffer_pkg;
  localparam int BUFFER_SIZE = 4;
  localparam int PACKET_SIZE = 49;
  localparam int PTR_LEN     = 2;
  localparam int VALID_BIT   = PACKET_SIZE - 1;

  typedef logic [PACKET_SIZE-1:0] packet_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } drain_state_t;
endpackage

// File: rtl/find_full_buffer_drain_rr_select.sv
// Round-robin finder: first set bit of vld_i searching upward from rr_ptr_i, modulo N.
module rr_occupied_select #(
  parameter int N       = 4,
  parameter int PTR_LEN = 2
) (
  input  logic [N-1:0]       vld_i,
  input  logic [PTR_LEN-1:0] rr_ptr_i,
  output logic [PTR_LEN-1:0] sel_o,
  output logic               found_o
);
  always_comb begin
    logic [PTR_LEN-1:0] idx;
    idx     = '0;
    sel_o   = '0;
    found_o = 1'b0;
    // N is a power of two, so PTR_LEN-bit addition wraps naturally.
    for (int k = 0; k < N; k++) begin
      idx = rr_ptr_i + PTR_LEN'(k);
      if (!found_o && vld_i[idx]) begin
        sel_o   = idx;
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/find_full_buffer_drain.sv
// Buffer read side: round-robin drain of occupied slots into a valid/ready output register.
// Optional DRAIN_STATS_EN adds saturating drain_cnt / stall_cnt outputs.
module find_full_buffer_drain
  import ring_buffer_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer,
  output logic                                    clr_en,
  output logic [PTR_LEN-1:0]                      clr_pos,
  output logic [PACKET_SIZE-1:0]                  out_pkt,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PTR_LEN:0]                        occ_count
`ifdef DRAIN_STATS_EN
  ,
  output logic [15:0]                             drain_cnt,
  output logic [15:0]                             stall_cnt
`endif
);
  drain_state_t         state_q, state_d;
  packet_t              out_pkt_q, out_pkt_d;
  logic [PTR_LEN-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BUFFER_SIZE-1:0] vld;
  logic [PTR_LEN-1:0]   sel;
  logic                 found, load;

  for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_vld
    assign vld[i] = buffer[i][VALID_BIT];
  end

  rr_occupied_select #(.N(BUFFER_SIZE), .PTR_LEN(PTR_LEN)) u_sel (
    .vld_i   (vld),
    .rr_ptr_i(rr_ptr_q),
    .sel_o   (sel),
    .found_o (found)
  );

  always_comb begin
    occ_count = '0;
    for (int i = 0; i < BUFFER_SIZE; i++) occ_count = occ_count + (PTR_LEN+1)'(vld[i]);
  end

  assign load    = found && (state_q == EMPTY || out_ready);
  // Clear request must stay quiet while the owner is held in reset.
  assign clr_en  = load && !rst;
  assign clr_pos = clr_en ? sel : '0;

  always_comb begin
    state_d   = state_q;
    out_pkt_d = out_pkt_q;
    rr_ptr_d  = rr_ptr_q;
    if (load) begin
      state_d   = HOLD;
      out_pkt_d = buffer[sel];
      rr_ptr_d  = sel + PTR_LEN'(1);
    end else if (state_q == HOLD && out_ready) begin
      state_d   = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      out_pkt_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      out_pkt_q <= out_pkt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_pkt   = out_pkt_q;

`ifdef DRAIN_STATS_EN
  logic [15:0] drain_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_valid && out_ready && drain_cnt_q != 16'hFFFF) drain_cnt_q <= drain_cnt_q + 16'd1;
      if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign drain_cnt = drain_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_find_full_buffer_drain.sv
// Self-checking bench: buffer-owner model, directed vector table, and a randomized scoreboard run.
module tb_find_full_buffer_drain;
  import ring_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] tb_buf;
  logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] wr_data;
  logic [BUFFER_SIZE-1:0] wr_en;
  logic                   out_ready;
  logic                   clr_en;
  logic [PTR_LEN-1:0]     clr_pos;
  logic [PACKET_SIZE-1:0] out_pkt;
  logic                   out_valid;
  logic [PTR_LEN:0]       occ_count;
`ifdef DRAIN_STATS_EN
  logic [15:0] drain_cnt, stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  find_full_buffer_drain dut (
    .clk      (clk),
    .rst      (rst),
    .buffer   (tb_buf),
    .clr_en   (clr_en),
    .clr_pos  (clr_pos),
    .out_pkt  (out_pkt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occ_count(occ_count)
`ifdef DRAIN_STATS_EN
    ,
    .drain_cnt(drain_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  // Buffer owner: writes only fill empty slots; the clear wins any same-slot conflict.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_buf <= '0;
    else begin
      for (int i = 0; i < BUFFER_SIZE; i++)
        if (wr_en[i] && !tb_buf[i][VALID_BIT]) tb_buf[i] <= wr_data[i];
      if (clr_en) tb_buf[clr_pos][VALID_BIT] <= 1'b0;
    end
  end

  function automatic packet_t pk(input int t);
    packet_t p;
    p = packet_t'(t);
    p[VALID_BIT] = 1'b1;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] wr, input int base, input logic rdy);
    @(negedge clk);
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      wr_en[i]   = wr[i];
      wr_data[i] = pk(base + i);
    end
    out_ready = rdy;
    #1;
  endtask

  typedef struct {
    logic [3:0] wr;
    int         base;
    logic       rdy;
    logic       eclr;
    int         epos;
    logic       evld;
    int         etag;
    int         eocc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] wr, input int base, input logic rdy,
                              input logic eclr, input int epos, input logic evld,
                              input int etag, input int eocc);
    vec_t v;
    v.wr = wr; v.base = base; v.rdy = rdy; v.eclr = eclr;
    v.epos = epos; v.evld = evld; v.etag = etag; v.eocc = eocc;
    return v;
  endfunction

  // Random-phase scoreboard state
  bit   written [0:11999];
  bit   emitted [0:11999];
  int   ntag, n_emit, m_rr, m_hs, m_stalls;
  bit   m_hold;
  packet_t m_pkt, prev_pkt;
  bit   prev_stall;
`ifdef DRAIN_STATS_EN
  int   snap_drain, snap_stall;
`endif

  initial begin
    wr_en = '0; wr_data = '0; out_ready = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_pkt", 64'(out_pkt), 64'(0));
    chk("rst_clr_en", 64'(clr_en), 64'(0));
    chk("rst_clr_pos", 64'(clr_pos), 64'(0));
    chk("rst_occ", 64'(occ_count), 64'(0));
    @(negedge clk); rst = 1'b0;

    // Reset mid-HOLD, then the first drain restarts at slot 0
    drive(4'b0100, 0, 1'b0);
    chk("t1_idle_valid", 64'(out_valid), 64'(0));
    drive(4'b0000, 0, 1'b0);
    chk("t1_clr_en", 64'(clr_en), 64'(1));
    chk("t1_clr_pos", 64'(clr_pos), 64'(2));
    drive(4'b0000, 0, 1'b0);
    chk("t1_hold_valid", 64'(out_valid), 64'(1));
    chk("t1_hold_pkt", 64'(out_pkt), 64'(pk(2)));
    #2 rst = 1'b1;
    #1;
    chk("t1_async_valid", 64'(out_valid), 64'(0));
    chk("t1_async_clr", 64'(clr_en), 64'(0));
    chk("t1_async_pkt", 64'(out_pkt), 64'(0));
    @(negedge clk); rst = 1'b0;
    drive(4'b1111, 40, 1'b1);
    chk("t1_post_valid", 64'(out_valid), 64'(0));
    drive(4'b0000, 0, 1'b1);
    chk("t1_post_clr_en", 64'(clr_en), 64'(1));
    chk("t1_post_clr_pos", 64'(clr_pos), 64'(0));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Directed table: slots 1,3; full buffer with stall; wrap-around
    vecs.push_back(mk(4'b1010, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 1, 0, 0, 2));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 3, 1, 1, 1));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 1, 3, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1111, 10, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 1, 0, 0, 0, 4));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 10, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 1, 1, 10, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 2, 1, 11, 2));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 3, 1, 12, 1));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 1, 13, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 20, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 2, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 1, 22, 0));
    vecs.push_back(mk(4'b1001, 30, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 3, 0, 0, 2));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 0, 1, 33, 1));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 1, 30, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].base, vecs[i].rdy);
      chk($sformatf("vec%0d_clr_en", i), 64'(clr_en), 64'(vecs[i].eclr));
      if (vecs[i].eclr) chk($sformatf("vec%0d_clr_pos", i), 64'(clr_pos), 64'(vecs[i].epos));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].evld));
      if (vecs[i].evld) chk($sformatf("vec%0d_pkt", i), 64'(out_pkt), 64'(pk(vecs[i].etag)));
      chk($sformatf("vec%0d_occ", i), 64'(occ_count), 64'(vecs[i].eocc));
`ifdef DRAIN_STATS_EN
      if (i == 5) begin snap_drain = int'(drain_cnt); snap_stall = int'(stall_cnt); end
      if (i == 16) begin
        chk("t3_drain_cnt", 64'(int'(drain_cnt) - snap_drain), 64'(4));
        chk("t3_stall_cnt", 64'(int'(stall_cnt) - snap_stall), 64'(5));
      end
`endif
    end

    // Empty buffer idles quietly
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, 0, 1'($urandom % 2));
      chk("t5_valid", 64'(out_valid), 64'(0));
      chk("t5_clr_en", 64'(clr_en), 64'(0));
      chk("t5_occ", 64'(occ_count), 64'(0));
    end

    // Randomized run against a slot-level reference model
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ntag = 0; n_emit = 0; m_rr = 0; m_hold = 0; m_pkt = '0; m_hs = 0; m_stalls = 0;
    prev_stall = 0; prev_pkt = '0;
    for (int c = 0; c < 10000; c++) begin
      int  cnt, sel, t;
      bit  found, load, rdy;
      @(negedge clk);
      if (c >= 9970) rdy = 1'b1;
      else rdy = ($urandom_range(0, 9) < (((c / 1000) % 2) != 0 ? 8 : 3));
      out_ready = rdy;
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        wr_en[i] = 1'b0;
        if (c < 9970 && !tb_buf[i][VALID_BIT] && ($urandom % 3) == 0 && ntag < 12000) begin
          wr_en[i]      = 1'b1;
          wr_data[i]    = pk(ntag);
          written[ntag] = 1'b1;
          ntag++;
        end
      end
      #1;
      found = 0; sel = 0; cnt = 0;
      for (int k = 0; k < BUFFER_SIZE; k++) begin
        int idx;
        idx = (m_rr + k) % BUFFER_SIZE;
        if (!found && tb_buf[idx][VALID_BIT]) begin found = 1; sel = idx; end
        cnt += int'(tb_buf[k][VALID_BIT]);
      end
      load = found && (!m_hold || rdy);
      chk("rnd_valid", 64'(out_valid), 64'(m_hold));
      if (m_hold) chk("rnd_pkt", 64'(out_pkt), 64'(m_pkt));
      chk("rnd_clr_en", 64'(clr_en), 64'(load));
      if (load) chk("rnd_clr_pos", 64'(clr_pos), 64'(sel));
      chk("rnd_occ", 64'(occ_count), 64'(cnt));
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_pkt_stable", 64'(out_pkt), 64'(prev_pkt));
      end
      if (out_valid && out_ready) begin
        t = int'(out_pkt[VALID_BIT-1:0]);
        chk("emit_known", 64'(t < ntag && written[t]), 64'(1));
        if (t < 12000) begin
          chk("emit_once", 64'(emitted[t]), 64'(0));
          emitted[t] = 1'b1;
        end
        n_emit++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pkt   = out_pkt;
      if (m_hold && rdy) m_hs++;
      if (m_hold && !rdy) m_stalls++;
      if (load) begin
        m_hold = 1; m_pkt = tb_buf[sel]; m_rr = (sel + 1) % BUFFER_SIZE;
      end else if (m_hold && rdy) m_hold = 0;
    end
    @(negedge clk); #1;
    chk("all_emitted", 64'(n_emit), 64'(ntag));
    chk("final_idle", 64'(out_valid), 64'(0));
`ifdef DRAIN_STATS_EN
    chk("rnd_drain_cnt", 64'(drain_cnt), 64'(m_hs));
    chk("rnd_stall_cnt", 64'(stall_cnt), 64'(m_stalls));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
